// File: rtl/sad_best_sel.sv
// Block-SAD accumulator and best-candidate selector: sums BLK_LEN per-sample SADs per
// candidate, tracks the minimum over NUM_CAND candidates and holds the winner until taken.
module sad_best_sel #(
    parameter int W        = 8,
    parameter int BLK_LEN  = 16,
    parameter int NUM_CAND = 4,
    localparam int SW      = W + 2 + $clog2(BLK_LEN),
    localparam int IW      = ($clog2(NUM_CAND) > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [W+1:0]  in_sad,
    input  logic          in_vld,
    output logic          in_rdy,
    output logic [SW-1:0] out_min,
    output logic [IW-1:0] out_idx,
    output logic          out_vld,
    input  logic          out_rdy
);

    localparam int SCW = ($clog2(BLK_LEN) > 1) ? $clog2(BLK_LEN) : 1;
    localparam logic [SCW-1:0] SCNT_LAST = SCW'(BLK_LEN - 1);
    localparam logic [IW-1:0]  CCNT_LAST = IW'(NUM_CAND - 1);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_RES = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [SCW-1:0]  scnt_reg, scnt_next;
    logic [IW-1:0]   ccnt_reg, ccnt_next;
    logic [SW-1:0]   acc_reg, acc_next;
    logic [SW-1:0]   bmin_reg, bmin_next;
    logic [IW-1:0]   bidx_reg, bidx_next;
    logic [SW-1:0]   out_min_reg, out_min_next;
    logic [IW-1:0]   out_idx_reg, out_idx_next;

    logic            acc_in;
    logic            last_smp;
    logic            last_cand;
    logic            take_blk;
    logic            done;
    logic [SW-1:0]   blk_sum;
    logic [SW-1:0]   cand_min;
    logic [IW-1:0]   cand_idx;

    assign out_vld = (state_reg == ST_RES);
    assign in_rdy  = ~out_vld | out_rdy;
    assign out_min = out_min_reg;
    assign out_idx = out_idx_reg;

    assign acc_in    = in_vld & in_rdy;
    assign last_smp  = (scnt_reg == SCNT_LAST);
    assign last_cand = (ccnt_reg == CCNT_LAST);

    // The first sample of a block restarts the sum, so acc never needs an explicit clear.
    assign blk_sum = ((scnt_reg == '0) ? '0 : acc_reg) + SW'(in_sad);

    // Strict less-than keeps the earlier candidate on a tie.
    assign take_blk = (ccnt_reg == '0) || (blk_sum < bmin_reg);
    assign cand_min = take_blk ? blk_sum : bmin_reg;
    assign cand_idx = take_blk ? ccnt_reg : bidx_reg;

    assign done = acc_in & ~clr & last_smp & last_cand;

    always_comb begin
        scnt_next    = scnt_reg;
        ccnt_next    = ccnt_reg;
        acc_next     = acc_reg;
        bmin_next    = bmin_reg;
        bidx_next    = bidx_reg;
        out_min_next = out_min_reg;
        out_idx_next = out_idx_reg;
        if (clr) begin
            scnt_next = '0;
            ccnt_next = '0;
            acc_next  = '0;
            bmin_next = '0;
            bidx_next = '0;
        end else if (acc_in) begin
            if (!last_smp) begin
                acc_next  = blk_sum;
                scnt_next = scnt_reg + SCW'(1);
            end else begin
                scnt_next = '0;
                bmin_next = cand_min;
                bidx_next = cand_idx;
                if (last_cand) begin
                    ccnt_next    = '0;
                    out_min_next = cand_min;
                    out_idx_next = cand_idx;
                end else begin
                    ccnt_next = ccnt_reg + IW'(1);
                end
            end
        end
    end

    // Result state machine; the state bit itself is out_vld.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACC: begin
                if (done) state_next = ST_RES;
            end
            ST_RES: begin
                if (done)         state_next = ST_RES;
                else if (out_rdy) state_next = ST_ACC;
            end
            default: state_next = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_ACC;
            scnt_reg    <= '0;
            ccnt_reg    <= '0;
            acc_reg     <= '0;
            bmin_reg    <= '0;
            bidx_reg    <= '0;
            out_min_reg <= '0;
            out_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            scnt_reg    <= scnt_next;
            ccnt_reg    <= ccnt_next;
            acc_reg     <= acc_next;
            bmin_reg    <= bmin_next;
            bidx_reg    <= bidx_next;
            out_min_reg <= out_min_next;
            out_idx_reg <= out_idx_next;
        end
    end

endmodule
